// File: rtl/simple_fifo.sv
// Single-clock byte FIFO with registered read data, occupancy count and
// sticky-free overflow/underflow pulses. Rejected requests never touch state.
module simple_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned PTR_WIDTH = ADDR_WIDTH + 1;
    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;

    // A full FIFO still accepts a write when a read frees a slot at the same edge.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    assign full         = (count == CNT_WIDTH'(DEPTH));
    assign empty        = (count == CNT_WIDTH'(0));
    assign almost_full  = (count == CNT_WIDTH'(DEPTH - 1));
    assign almost_empty = (count == CNT_WIDTH'(1));

    // Storage is intentionally left uncleared by reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + PTR_WIDTH'(1);
                data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
            overflow  <= wr_en && !wr_ok;
            underflow <= rd_en && empty;
        end
    end

endmodule

// File: tb/tb_simple_fifo.sv
// Self-checking bench for simple_fifo: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_simple_fifo;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic [7:0] m_dout;
    logic       m_ovf;
    logic       m_unf;

    simple_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .ADDR_WIDTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .data_in      (data_in),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Drive one clock of requests and advance the reference model.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        int sz;
        bit rok;
        bit wok;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        sz  = q.size();
        rok = r && (sz > 0);
        wok = w && ((sz < DEPTH) || rok);
        if (rok) m_dout = q.pop_front();
        if (wok) q.push_back(d);
        m_ovf = w && !wok;
        m_unf = r && (sz == 0);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({empty, full, count, data_out, overflow, underflow} !== {1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_init: empty=%b full=%b count=%0d dout=%h ovf=%b unf=%b, want 1 0 0 00 0 0",
                     empty, full, count, data_out, overflow, underflow);
        end
        @(negedge clk) rst = 1'b0;
        cycle(1'b1, 1'b0, 8'hA1);
        cycle(1'b1, 1'b0, 8'hA2);
        cycle(1'b1, 1'b1, 8'hA3);
        #2 rst = 1'b1;
        #1;
        q.delete();
        m_dout = 8'h00;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        checks++;
        if ({empty, full, count, data_out, almost_full, almost_empty} !== {1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_async: empty=%b full=%b count=%0d dout=%h af=%b ae=%b, want 1 0 0 00 0 0",
                     empty, full, count, data_out, almost_full, almost_empty);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (underflow !== 1'b1 || data_out !== 8'h00 || count !== 3'd0) begin
            failures++;
            $display("FAIL reset_discard: unf=%b dout=%h count=%0d, want 1 00 0", underflow, data_out, count);
        end
        cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 1'b0, 8'(i));
            checks++;
            if (almost_full !== (i == 3) || full !== (i == 4) || count !== 3'(i)) begin
                failures++;
                $display("FAIL fill_%0d: af=%b full=%b count=%0d, want %b %b %0d",
                         i, almost_full, full, count, (i == 3), (i == 4), i);
            end
        end
        cycle(1'b1, 1'b0, 8'h05);
        checks++;
        if (overflow !== 1'b1 || count !== 3'd4 || full !== 1'b1) begin
            failures++;
            $display("FAIL fill_overflow: ovf=%b count=%0d full=%b, want 1 4 1", overflow, count, full);
        end
        cycle(1'b0, 1'b0, 8'h00);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL fill_ovf_pulse: ovf=%b, want 0", overflow);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            checks++;
            if (data_out !== 8'(i) || empty !== (i == 4) || underflow !== 1'b0) begin
                failures++;
                $display("FAIL drain_%0d: dout=%h empty=%b unf=%b, want %h %b 0",
                         i, data_out, empty, underflow, 8'(i), (i == 4));
            end
        end
        cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (underflow !== 1'b1 || data_out !== 8'h04 || count !== 3'd0) begin
            failures++;
            $display("FAIL drain_underflow: unf=%b dout=%h count=%0d, want 1 04 0", underflow, data_out, count);
        end
        cycle(1'b0, 1'b0, 8'h00);
        checks++;
        if (underflow !== 1'b0 || data_out !== 8'h04) begin
            failures++;
            $display("FAIL drain_unf_pulse: unf=%b dout=%h, want 0 04", underflow, data_out);
        end
    endtask

    task automatic test_concurrent();
        logic [7:0] want [5];
        want = '{8'h50, 8'h51, 8'd10, 8'd11, 8'd12};
        cycle(1'b1, 1'b0, 8'h50);
        cycle(1'b1, 1'b0, 8'h51);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 8'(10 + i));
            checks++;
            if (data_out !== want[i] || count !== 3'd2 ||
                {full, empty, almost_full, almost_empty, overflow, underflow} !== 6'b0) begin
                failures++;
                $display("FAIL concurrent_%0d: dout=%h count=%0d flags=%b, want %h 2 000000",
                         i, data_out, count,
                         {full, empty, almost_full, almost_empty, overflow, underflow}, want[i]);
            end
        end
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (data_out !== 8'd14 || empty !== 1'b1) begin
            failures++;
            $display("FAIL concurrent_tail: dout=%h empty=%b, want 0e 1", data_out, empty);
        end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h20 + 4 * r + i));
            checks++;
            if (full !== 1'b1 || count !== 3'd4) begin
                failures++;
                $display("FAIL wrap_full_%0d: full=%b count=%0d, want 1 4", r, full, count);
            end
            for (int i = 0; i < 4; i++) begin
                cycle(1'b0, 1'b1, 8'h00);
                checks++;
                if (data_out !== 8'(8'h20 + 4 * r + i)) begin
                    failures++;
                    $display("FAIL wrap_data_%0d_%0d: dout=%h, want %h", r, i, data_out, 8'(8'h20 + 4 * r + i));
                end
            end
            checks++;
            if (empty !== 1'b1 || full !== 1'b0) begin
                failures++;
                $display("FAIL wrap_empty_%0d: empty=%b full=%b, want 1 0", r, empty, full);
            end
        end
    endtask

    task automatic test_edge();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i));
        cycle(1'b1, 1'b1, 8'h64);
        checks++;
        if (data_out !== 8'h60 || full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL edge_full_rw: dout=%h full=%b count=%0d ovf=%b, want 60 1 4 0",
                     data_out, full, count, overflow);
        end
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            checks++;
            if (data_out !== 8'(8'h60 + i)) begin
                failures++;
                $display("FAIL edge_drain_%0d: dout=%h, want %h", i, data_out, 8'(8'h60 + i));
            end
        end
        cycle(1'b1, 1'b1, 8'h70);
        checks++;
        if (count !== 3'd1 || underflow !== 1'b1 || data_out !== 8'h64 || almost_empty !== 1'b1) begin
            failures++;
            $display("FAIL edge_empty_rw: count=%0d unf=%b dout=%h ae=%b, want 1 1 64 1",
                     count, underflow, data_out, almost_empty);
        end
        cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (data_out !== 8'h70 || empty !== 1'b1) begin
            failures++;
            $display("FAIL edge_readback: dout=%h empty=%b, want 70 1", data_out, empty);
        end
    endtask

    task automatic test_random();
        int sz;
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
            sz = q.size();
            checks++;
            if (data_out !== m_dout || count !== 3'(sz) || overflow !== m_ovf || underflow !== m_unf ||
                full !== (sz == DEPTH) || empty !== (sz == 0) ||
                almost_full !== (sz == DEPTH - 1) || almost_empty !== (sz == 1)) begin
                failures++;
                $display("FAIL random_%0d: dout=%h count=%0d ovf=%b unf=%b f=%b e=%b af=%b ae=%b, want %h %0d %b %b",
                         n, data_out, count, overflow, underflow, full, empty, almost_full, almost_empty,
                         m_dout, sz, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        clk     = 1'b0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = 8'h00;
        m_dout  = 8'h00;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_concurrent();
        test_wrap();
        test_edge();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simple_fifo.md
Name: simple_fifo

Overview:
Synchronous single-clock FIFO, 8-bit data, 4 entries by default. Buffers bytes between a producer and a consumer in the same clock domain. Uses registered read data, full/empty status flags and occupancy/error status. Overflowing writes and underflowing reads are dropped, never corrupting state.

Parameters:
DATA_WIDTH, 8, width of data_in/data_out and each storage entry
DEPTH, 4, number of entries; must be a power of two and at least 2
ADDR_WIDTH, 2, log2(DEPTH); pointer width (pointers carry one extra wrap bit)

Ports:
clk  input  1  single clock; all state changes on rising edge
rst  input  1  reset, asynchronous assert, active-high; clears all state
wr_en  input  1  write request, sampled on rising clk
rd_en  input  1  read request, sampled on rising clk
data_in  input  DATA_WIDTH  write data, captured when write accepted
data_out  output  DATA_WIDTH  registered read data
full  output  1  high when count == DEPTH
empty  output  1  high when count == 0
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
almost_full  output  1  high when count == DEPTH-1
almost_empty  output  1  high when count == 1
overflow  output  1  one-cycle pulse: write requested while full and not accepted
underflow  output  1  one-cycle pulse: read requested while empty

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset: wr_ptr=0, rd_ptr=0, count=0, data_out=0, empty=1, full=0, almost_*=0, overflow=0, underflow=0. Memory contents are not cleared. Reset mid-operation discards all stored data immediately.
- Write accept (wr_ok) = wr_en && (!full || rd_ok). On wr_ok: mem[wr_ptr] <= data_in, wr_ptr increments modulo 2*DEPTH; its low ADDR_WIDTH bits index memory.
- Read accept (rd_ok) = rd_en && !empty. On rd_ok: data_out <= mem[rd_ptr] at that edge (1-cycle latency), rd_ptr increments.
- data_out holds its last value when no read is accepted, including reads attempted while empty.
- Simultaneous wr_en and rd_en:
  - When full: both accepted; count stays DEPTH.
  - When empty: write accepted, read rejected (no fall-through bypass); underflow pulses; count becomes 1.
  - Otherwise: both accepted; count unchanged.
- count: +1 on write-only, -1 on read-only, unchanged on both or neither.
- Flags derive combinationally from registered count, so they update in the cycle after the accepting edge.
- Ordering: strict first-in first-out across pointer wrap-around; no loss or duplication.
- overflow/underflow: registered, high for exactly the cycle after the offending edge.

Test Plan:
- Reset: assert rst for 2 cycles mid-stream -> empty=1, full=0, count=0, data_out=0 immediately; earlier data never read back.
- Fill: write 1,2,3,4 -> almost_full after 3, full=1 after 4. Write 5 while full -> overflow pulse, count stays 4, value 5 never appears.
- Drain: rd_en high 5 cycles -> data_out 1,2,3,4 on successive cycles. empty=1 after 4th read. 5th read -> underflow pulse, data_out holds 4.
- Concurrent: with 2 entries queued, write 10..14 while reading each cycle -> outputs in order, count constant, no flags asserted.
- Wrap-around: 3 full/empty cycles of 4 writes and 4 reads (values 0x20..0x2B) -> exact order preserved, full/empty correct at each boundary.
- Edge cases: simultaneous read+write when full -> oldest value output, new value stored, full stays 1. Simultaneous read+write when empty -> count=1, underflow pulse, data_out unchanged.
